doorlock_ctrl_p: RTL and testbench
==================================

DOORLOCK_CTRL_P -- requirements
Module: doorlock_ctrl_p

Interface
REQ-001 The block SHALL have parameter SEED_W, default 32, width of seed and free-running counter.
REQ-002 The block SHALL have parameter ERR_W, default 4, width of err_cnt.
REQ-003 The block SHALL have parameter MAX_ERR, default 5, number of consecutive failed challenges that triggers LOCKOUT (1..2^ERR_W-1).
REQ-004 The block SHALL have parameter SHUFFLE_CYC, default 10, cycles spent in SHUFFLE.
REQ-005 The block SHALL have parameter UNLOCK_CYC, default 15000000, idle cycles in UNLOCKED before auto-relock.
REQ-006 The block SHALL have parameter LOCKOUT_CYC, default 30000000, cycles spent in LOCKOUT.
REQ-007 The block SHALL have port clk  in  1  single clock, all logic on the rising edge.
REQ-008 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-009 The block SHALL have ports confirm / shuffle  in  1 each  single-cycle debounced button pulses.
REQ-010 The block SHALL have ports input_valid / limit  in  1 each  digit-entered strobe / digit store full.
REQ-011 The block SHALL have ports same / master_same  in  1 each  buffer equals user / master password.
REQ-012 The block SHALL have ports mem_sl, mem_rst, buff_sl, buff_rst  out  1 each  registered one-cycle pulses to the password stores.
REQ-013 The block SHALL have ports shuffle_init  out  1, decision  out  1 (1 = door open/programmable), seed  out  SEED_W, state  out  3, err_cnt  out  ERR_W.

Function
REQ-014 State encoding SHALL be SET=0, CONFIRM=1, SHUFFLE=2, LOCKED=3, CHALLENGE=4, UNLOCKED=5, LOCKOUT=6; 7 is unreachable and SHALL recover to SET on the next edge.
REQ-015 All outputs SHALL be registered and SHALL reflect the decision made on the same clock edge as the state update.
REQ-016 Pulse outputs SHALL default to 0 every cycle unless asserted by a rule below.
REQ-017 Input priority within one cycle SHALL be shuffle > confirm > input_valid.
REQ-018 A free-running SEED_W counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-019 A single timer SHALL clear on every state change and increment each cycle in SHUFFLE, UNLOCKED and LOCKOUT.
REQ-020 SET: on shuffle, go to SHUFFLE with return=SET; on confirm, pulse buff_rst and go to CONFIRM; on input_valid&~limit, pulse mem_sl; on input_valid&limit, pulse mem_rst.
REQ-021 CONFIRM: on shuffle, go to SHUFFLE with return=CONFIRM; on confirm&same, go to LOCKED with err_cnt=0; on (confirm&~same) or (input_valid&limit), pulse mem_rst and buff_rst and go to SET; on input_valid&~limit, pulse buff_sl.
REQ-022 Entry to SHUFFLE SHALL latch seed <= free counter, set shuffle_init=1 and latch the return state.
REQ-023 SHUFFLE SHALL last exactly SHUFFLE_CYC cycles, ignore all button and input activity, then clear shuffle_init and return.
REQ-024 LOCKED: on confirm, pulse buff_rst and go to CHALLENGE; shuffle and input_valid SHALL be ignored.
REQ-025 CHALLENGE: on shuffle, go to SHUFFLE with return=CHALLENGE; on input_valid&~limit, pulse buff_sl.
REQ-026 CHALLENGE: on confirm&(same|master_same), clear err_cnt and go to UNLOCKED.
REQ-027 CHALLENGE: on confirm without a match, or on input_valid&limit, increment err_cnt (saturating at 2^ERR_W-1); go to LOCKOUT if the new value is >= MAX_ERR, else to LOCKED.
REQ-028 UNLOCKED: on confirm, go to LOCKED; on shuffle, pulse mem_rst and go to SET (reprogram); with neither, go to LOCKED when the timer reaches UNLOCK_CYC-1.
REQ-029 LOCKOUT SHALL ignore every input, including master_same; after LOCKOUT_CYC cycles it SHALL clear err_cnt and go to LOCKED.
REQ-030 decision SHALL be 1 in SET and UNLOCKED, 0 in CONFIRM, LOCKED, CHALLENGE and LOCKOUT, and held during SHUFFLE.

Reset
REQ-031 While rst_n=0, the block SHALL hold state=SET, decision=1, shuffle_init=0, all pulses 0, seed=0, err_cnt=0, timer=0, free counter=0 and return state=SET.
REQ-032 Reset asserted mid-SHUFFLE or mid-LOCKOUT SHALL abort immediately with no residual pulse after release.

Verification
REQ-033 Bench SHALL cover enrolment: 4 input_valid in SET -> 4 mem_sl pulses; confirm -> buff_rst, CONFIRM; 4 input_valid -> 4 buff_sl; confirm with same=1 -> LOCKED, decision=0.
REQ-034 Bench SHALL cover shuffle: shuffle in CHALLENGE at free counter=0x1234 -> seed=0x1234; shuffle_init high for exactly 10 cycles; state returns to 4; confirm during SHUFFLE has no effect.
REQ-035 Bench SHALL cover lockout: 5 failed confirms in CHALLENGE -> err_cnt 1..5, LOCKOUT on the fifth; master_same=1 with confirm during LOCKOUT is ignored; LOCKED with err_cnt=0 after LOCKOUT_CYC (override to 20).
REQ-036 Bench SHALL cover auto-relock: UNLOCK_CYC=8; UNLOCKED with no input -> LOCKED exactly 8 cycles after entry; confirm at cycle 3 -> LOCKED immediately.
REQ-037 Bench SHALL cover simultaneous events: shuffle and confirm in the same cycle in SET -> SHUFFLE with no buff_rst; input_valid&limit in CONFIRM -> mem_rst and buff_rst, SET.
REQ-038 Bench SHALL cover reset: rst_n pulled low mid-SHUFFLE -> state=0, shuffle_init=0, decision=1 asynchronously.

Source files
------------

// File: rtl/doorlock_ctrl_p.sv
// Door-lock sequencer: password enrolment, challenge/response with lockout,
// keypad shuffle seeding and timed auto-relock.
module doorlock_ctrl_p #(
   parameter int SEED_W      = 32,
   parameter int ERR_W       = 4,
   parameter int MAX_ERR     = 5,
   parameter int SHUFFLE_CYC = 10,
   parameter int UNLOCK_CYC  = 15000000,
   parameter int LOCKOUT_CYC = 30000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              confirm,
   input  logic              shuffle,
   input  logic              input_valid,
   input  logic              limit,
   input  logic              same,
   input  logic              master_same,
   output logic              mem_sl,
   output logic              mem_rst,
   output logic              buff_sl,
   output logic              buff_rst,
   output logic              shuffle_init,
   output logic              decision,
   output logic [SEED_W-1:0] seed,
   output logic [2:0]        state,
   output logic [ERR_W-1:0]  err_cnt
);

   // state     | meaning
   // SET       | door open, user password being entered
   // CONFIRM   | re-entry of new password for confirmation
   // SHUFFLE   | keypad scramble in progress, inputs ignored
   // LOCKED    | door shut, waiting for confirm to start a challenge
   // CHALLENGE | password entry against user/master password
   // UNLOCKED  | door open, relocks on confirm or idle timeout
   // LOCKOUT   | too many failures, all inputs ignored
   typedef enum logic [2:0] {
      ST_SET       = 3'd0,
      ST_CONFIRM   = 3'd1,
      ST_SHUFFLE   = 3'd2,
      ST_LOCKED    = 3'd3,
      ST_CHALLENGE = 3'd4,
      ST_UNLOCKED  = 3'd5,
      ST_LOCKOUT   = 3'd6
   } state_t;

   localparam int TMR_MAX0 = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int TMR_MAX  = (TMR_MAX0 > SHUFFLE_CYC) ? TMR_MAX0 : SHUFFLE_CYC;
   localparam int TMR_W    = $clog2(TMR_MAX + 1);

   // down-counter reload values; each timed state exits on terminal count 0
   localparam logic [TMR_W-1:0] SHUF_LD = TMR_W'(SHUFFLE_CYC - 1);
   localparam logic [TMR_W-1:0] UNLK_LD = TMR_W'(UNLOCK_CYC - 1);
   localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCKOUT_CYC - 1);
   localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(MAX_ERR);

   state_t             st, ret_st;
   logic [TMR_W-1:0]   tmr;
   logic [SEED_W-1:0]  free_cnt;
   logic [ERR_W-1:0]   err_nxt;
   logic               shuf_ok;

   assign err_nxt = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
   assign shuf_ok = shuffle && (st == ST_SET || st == ST_CONFIRM || st == ST_CHALLENGE);
   assign state   = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= ST_SET;
         ret_st       <= ST_SET;
         tmr          <= '0;
         free_cnt     <= '0;
         seed         <= '0;
         err_cnt      <= '0;
         decision     <= 1'b1;
         shuffle_init <= 1'b0;
         mem_sl       <= 1'b0;
         mem_rst      <= 1'b0;
         buff_sl      <= 1'b0;
         buff_rst     <= 1'b0;
      end else begin
         free_cnt <= free_cnt + 1'b1;
         mem_sl   <= 1'b0;
         mem_rst  <= 1'b0;
         buff_sl  <= 1'b0;
         buff_rst <= 1'b0;
         if (shuf_ok) begin
            st           <= ST_SHUFFLE;
            ret_st       <= st;
            seed         <= free_cnt;
            shuffle_init <= 1'b1;
            tmr          <= SHUF_LD;
         end else begin
            case (st)
               ST_SET: begin
                  if (confirm) begin
                     buff_rst <= 1'b1;
                     st       <= ST_CONFIRM;
                     decision <= 1'b0;
                  end else if (input_valid) begin
                     mem_rst <= limit;
                     mem_sl  <= ~limit;
                  end
               end
               ST_CONFIRM: begin
                  if (confirm && same) begin
                     st      <= ST_LOCKED;
                     err_cnt <= '0;
                  end else if (confirm || (input_valid && limit)) begin
                     mem_rst  <= 1'b1;
                     buff_rst <= 1'b1;
                     st       <= ST_SET;
                     decision <= 1'b1;
                  end else if (input_valid) begin
                     buff_sl <= 1'b1;
                  end
               end
               ST_SHUFFLE: begin
                  if (tmr == '0) begin
                     st           <= ret_st;
                     shuffle_init <= 1'b0;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               ST_LOCKED: begin
                  if (confirm) begin
                     buff_rst <= 1'b1;
                     st       <= ST_CHALLENGE;
                  end
               end
               ST_CHALLENGE: begin
                  if (confirm && (same || master_same)) begin
                     err_cnt  <= '0;
                     st       <= ST_UNLOCKED;
                     decision <= 1'b1;
                     tmr      <= UNLK_LD;
                  end else if (confirm || (input_valid && limit)) begin
                     err_cnt <= err_nxt;
                     if (err_nxt >= ERR_LIM) begin
                        st  <= ST_LOCKOUT;
                        tmr <= LOCK_LD;
                     end else begin
                        st <= ST_LOCKED;
                     end
                  end else if (input_valid) begin
                     buff_sl <= 1'b1;
                  end
               end
               ST_UNLOCKED: begin
                  if (shuffle) begin
                     mem_rst <= 1'b1;
                     st      <= ST_SET;
                  end else if (confirm || tmr == '0) begin
                     st       <= ST_LOCKED;
                     decision <= 1'b0;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               ST_LOCKOUT: begin
                  if (tmr == '0) begin
                     err_cnt <= '0;
                     st      <= ST_LOCKED;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               default: begin
                  st           <= ST_SET;
                  decision     <= 1'b1;
                  shuffle_init <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_doorlock_ctrl_p.sv
// Directed bench for doorlock_ctrl_p: enrolment, shuffle, lockout, relock,
// simultaneous inputs and asynchronous reset.
module tb_doorlock_ctrl_p;

   logic        clk, rst_n;
   logic        confirm, shuffle, input_valid, limit, same, master_same;
   logic        mem_sl, mem_rst, buff_sl, buff_rst, shuffle_init, decision;
   logic [31:0] seed;
   logic [2:0]  state;
   logic [3:0]  err_cnt;
   logic [31:0] tb_cnt;
   int          n_chk, n_fail, n;

   doorlock_ctrl_p #(
      .SEED_W(32), .ERR_W(4), .MAX_ERR(5),
      .SHUFFLE_CYC(10), .UNLOCK_CYC(8), .LOCKOUT_CYC(20)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .confirm(confirm), .shuffle(shuffle),
      .input_valid(input_valid), .limit(limit),
      .same(same), .master_same(master_same),
      .mem_sl(mem_sl), .mem_rst(mem_rst), .buff_sl(buff_sl), .buff_rst(buff_rst),
      .shuffle_init(shuffle_init), .decision(decision),
      .seed(seed), .state(state), .err_cnt(err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // mirror of the free-running counter: cycles since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cnt <= 32'd0;
      else        tb_cnt <= tb_cnt + 32'd1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic c, input logic s, input logic iv, input logic lm,
                       input logic sm, input logic ms);
      confirm = c; shuffle = s; input_valid = iv; limit = lm; same = sm; master_same = ms;
      @(negedge clk);
      confirm = 0; shuffle = 0; input_valid = 0; limit = 0; same = 0; master_same = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 0;
      confirm = 0; shuffle = 0; input_valid = 0; limit = 0; same = 0; master_same = 0;
      #12;
      check_val("rst_state", 32'(state), 0);
      check_val("rst_decision", 32'(decision), 1);
      check_val("rst_shuffle_init", 32'(shuffle_init), 0);
      check_val("rst_pulses", 32'({mem_sl, mem_rst, buff_sl, buff_rst}), 0);
      check_val("rst_seed", seed, 0);
      check_val("rst_err", 32'(err_cnt), 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // enrolment
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 0, 0);
         check_val("enrol_mem_sl", 32'(mem_sl), 1);
      end
      step(0, 0, 0, 0, 0, 0);
      check_val("enrol_pulse_clear", 32'({mem_sl, mem_rst, buff_sl, buff_rst}), 0);
      step(1, 0, 0, 0, 0, 0);
      check_val("enrol_buff_rst", 32'(buff_rst), 1);
      check_val("enrol_confirm_state", 32'(state), 1);
      check_val("enrol_confirm_dec", 32'(decision), 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 0, 0);
         check_val("enrol_buff_sl", 32'(buff_sl), 1);
      end
      step(1, 0, 0, 0, 1, 0);
      check_val("enrol_locked", 32'(state), 3);
      check_val("enrol_locked_dec", 32'(decision), 0);

      // LOCKED ignores shuffle; confirm starts challenge
      step(0, 1, 0, 0, 0, 0);
      check_val("locked_ign_shuffle", 32'({state, shuffle_init}), 32'({3'd3, 1'b0}));
      step(1, 0, 0, 0, 0, 0);
      check_val("chal_entry", 32'({state, buff_rst}), 32'({3'd4, 1'b1}));

      // shuffle in CHALLENGE with free counter at 0x1234
      for (int k = 0; k < 10000 && tb_cnt != 32'h1234; k++) @(negedge clk);
      check_val("seed_align_wait", tb_cnt, 32'h1234);
      step(0, 1, 0, 0, 0, 0);
      check_val("shuf_state", 32'(state), 2);
      check_val("shuf_seed", seed, 32'h1234);
      check_val("shuf_dec_held", 32'(decision), 0);
      n = 1;
      for (int k = 0; k < 50; k++) begin
         step(k == 2, 0, k == 4, 0, 1, 0);
         if (shuffle_init) n++;
         else break;
      end
      check_val("shuf_len", 32'(n), 10);
      check_val("shuf_return", 32'(state), 4);
      check_val("shuf_no_pulse", 32'({buff_rst, buff_sl}), 0);

      // five failed challenges lead to lockout
      for (int i = 1; i <= 5; i++) begin
         step(1, 0, 0, 0, 0, 0);
         check_val("fail_err", 32'(err_cnt), 32'(i));
         check_val("fail_state", 32'(state), (i < 5) ? 3 : 6);
         if (i < 5) step(1, 0, 0, 0, 0, 0);
      end
      n = 1;
      for (int k = 0; k < 100; k++) begin
         step(k == 1, k == 6, k == 3, 0, k == 1, k == 1);
         if (k == 4) check_val("lockout_err_hold", 32'(err_cnt), 5);
         if (state == 3'd6) n++;
         else break;
      end
      check_val("lockout_len", 32'(n), 20);
      check_val("lockout_exit_state", 32'(state), 3);
      check_val("lockout_exit_err", 32'(err_cnt), 0);

      // auto-relock after 8 idle cycles
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      check_val("unlock_state", 32'(state), 5);
      check_val("unlock_dec", 32'(decision), 1);
      n = 1;
      for (int k = 0; k < 50; k++) begin
         step(0, 0, 0, 0, 0, 0);
         if (state == 3'd5) n++;
         else break;
      end
      check_val("relock_len", 32'(n), 8);
      check_val("relock_state", 32'({state, decision}), 32'({3'd3, 1'b0}));

      // confirm at cycle 3 relocks immediately
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check_val("early_still_unlocked", 32'(state), 5);
      step(1, 0, 0, 0, 0, 0);
      check_val("early_relock", 32'(state), 3);

      // reprogram from UNLOCKED
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0);
      check_val("reprog", 32'({state, mem_rst, decision}), 32'({3'd0, 1'b1, 1'b1}));

      // SET: input_valid with limit
      step(0, 0, 1, 1, 0, 0);
      check_val("set_limit", 32'({mem_rst, mem_sl}), 32'({1'b1, 1'b0}));

      // shuffle beats confirm in SET
      step(1, 1, 0, 0, 0, 0);
      check_val("simul_state", 32'({state, shuffle_init, buff_rst}), 32'({3'd2, 1'b1, 1'b0}));
      check_val("simul_dec_held", 32'(decision), 1);
      for (int k = 0; k < 50 && shuffle_init; k++) step(0, 0, 0, 0, 0, 0);
      check_val("simul_return", 32'(state), 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      check_val("confirm_limit", 32'({state, mem_rst, buff_rst}), 32'({3'd0, 1'b1, 1'b1}));

      // asynchronous reset mid-SHUFFLE
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check_val("pre_rst_shuffle", 32'(state), 2);
      #3 rst_n = 0;
      #1;
      check_val("async_rst", 32'({state, shuffle_init, decision}), 32'({3'd0, 1'b0, 1'b1}));
      check_val("async_rst_seed", seed, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      step(0, 0, 0, 0, 0, 0);
      check_val("post_rst", 32'({state, shuffle_init, mem_sl, mem_rst, buff_sl, buff_rst}), 32'({3'd0, 5'd0}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
